// File: rtl/player_motion_pkg.sv
// ---------------------------------------------------------------------------
// player_pkg
// Shared definitions for the knight sprite motion controller and its
// consumers (colour mapper): state encoding, keycodes, status codes, sprite
// geometry and motion tuning constants.
// ---------------------------------------------------------------------------
package player_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    JUMP = 2'd2
  } player_state_t;

  // USB HID keycodes
  localparam logic [7:0] KEY_A = 8'h04;  // move left
  localparam logic [7:0] KEY_D = 8'h07;  // move right
  localparam logic [7:0] KEY_W = 8'h1A;  // jump

  // Sprite select codes seen by the colour mapper
  localparam int STATUS_W = 4;
  localparam logic [STATUS_W-1:0] STATUS_IDLE = 4'd0;
  localparam logic [STATUS_W-1:0] STATUS_WALK = 4'd1;
  localparam logic [STATUS_W-1:0] STATUS_JUMP = 4'd2;

  // Sprite hitbox
  localparam logic [9:0] SPRITE_SIZE_X = 10'd30;
  localparam logic [9:0] SPRITE_SIZE_Y = 10'd64;

  // Motion tuning (pixels, pixels/frame)
  localparam int X_START   = 320;
  localparam int GROUND_Y  = 400;
  localparam int X_MIN     = 15;
  localparam int X_MAX     = 624;
  localparam int CEILING_Y = 32;
  localparam int WALK_STEP = 2;
  localparam int JUMP_V    = 10;
  localparam int GRAVITY   = 1;
  localparam int MAX_FALL  = 10;

endpackage

// File: rtl/player_motion_if.sv
// ---------------------------------------------------------------------------
// player_motion_if
// Bundles the keyboard/frame inputs and the sprite outputs of player_motion.
//   frame_clk   : vsync-rate level, asynchronous to Clk
//   keycode     : current HID keycode (0 = none)
//   BallX/BallY : sprite centre
//   Ball_sizeX/Y: sprite hitbox (constant)
//   BallStatus  : sprite select (idle/walk/airborne)
//   Facing      : 0 = right, 1 = left
// Modports: master = stimulus/keyboard side, slave = player_motion.
// ---------------------------------------------------------------------------
interface player_motion_if;
  import player_pkg::*;

  logic                frame_clk;
  logic [7:0]          keycode;
  logic [9:0]          BallX;
  logic [9:0]          BallY;
  logic [9:0]          Ball_sizeX;
  logic [9:0]          Ball_sizeY;
  logic [STATUS_W-1:0] BallStatus;
  logic                Facing;

  modport master (
    output frame_clk, keycode,
    input  BallX, BallY, Ball_sizeX, Ball_sizeY, BallStatus, Facing
  );

  modport slave (
    input  frame_clk, keycode,
    output BallX, BallY, Ball_sizeX, Ball_sizeY, BallStatus, Facing
  );

endinterface

// File: rtl/player_motion_frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen
// Brings the asynchronous frame_clk level into the clk domain through a
// flop synchroniser and emits a registered one-cycle pulse on each rising
// edge.
// Ports:
//   clk       : system clock
//   srst      : synchronous active-high reset
//   frame_clk : asynchronous vsync-rate level
//   tick      : one-clk pulse per frame_clk rising edge
// ---------------------------------------------------------------------------
module frame_tick_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic srst,
  input  logic frame_clk,
  output logic tick
);

  logic sync_reg [SYNC_STAGES];
  logic prev_reg;
  logic tick_reg;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= frame_clk;
        end
      end else begin : g_chain
        always_ff @(posedge clk) begin
          if (srst) sync_reg[gi] <= 1'b0;
          else      sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  // Edge detect on the synchronised level; the pulse itself is registered so
  // downstream logic sees a clean single-cycle strobe.
  always_ff @(posedge clk) begin
    if (srst) begin
      prev_reg <= 1'b0;
      tick_reg <= 1'b0;
    end else begin
      prev_reg <= sync_reg[SYNC_STAGES-1];
      tick_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/player_motion.sv
// ---------------------------------------------------------------------------
// player_motion
// Per-frame motion/state controller for the knight sprite. Once per frame
// tick it turns the keycode into a new centre position, facing and sprite
// status. Outputs change one Clk after the internal tick.
// Ports:
//   Clk   : system clock
//   Reset : synchronous active-high reset
//   bus   : player_motion_if.slave (frame_clk, keycode in; BallX, BallY,
//           Ball_sizeX, Ball_sizeY, BallStatus, Facing out)
// Optional feature: define PLAYER_DOUBLE_JUMP_EN to allow one extra jump
// while airborne.
// ---------------------------------------------------------------------------
module player_motion
  import player_pkg::*;
(
  input  logic            Clk,
  input  logic            Reset,
  player_motion_if.slave  bus
);

  logic tick;

  frame_tick_gen #(.SYNC_STAGES(2)) u_frame_tick_gen (
    .clk       (Clk),
    .srst      (Reset),
    .frame_clk (bus.frame_clk),
    .tick      (tick)
  );

  // State and datapath registers
  player_state_t     state_reg,      state_next;
  logic [9:0]        x_reg,          x_next;
  logic [9:0]        y_reg,          y_next;
  logic signed [5:0] vy_reg,         vy_next;
  logic              facing_reg,     facing_next;
  logic              jump_armed_reg, jump_armed_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
  logic              air_jump_avail_reg, air_jump_avail_next;
`endif

  // Key decode: one keycode at a time, so left/right are mutually exclusive
  logic key_left, key_right, key_jump, key_move;
  assign key_left  = (bus.keycode == KEY_A);
  assign key_right = (bus.keycode == KEY_D);
  assign key_jump  = (bus.keycode == KEY_W);
  assign key_move  = key_left | key_right;

  // Horizontal candidates widened to 11 bits so neither step can wrap
  logic [10:0] x_dec, x_inc;
  assign x_dec = {1'b0, x_reg} - 11'(WALK_STEP);
  assign x_inc = {1'b0, x_reg} + 11'(WALK_STEP);

  // Vertical candidates in signed 11-bit
  logic signed [10:0] y_sum;
  logic signed [5:0]  vy_inc, vy_fall;
  logic               hit_ground, hit_ceiling;
  assign y_sum       = $signed({1'b0, y_reg}) + 11'(vy_reg);
  assign vy_inc      = vy_reg + $signed(6'(GRAVITY));
  assign vy_fall     = (vy_inc > $signed(6'(MAX_FALL))) ? $signed(6'(MAX_FALL)) : vy_inc;
  assign hit_ground  = (y_sum >= $signed(11'(GROUND_Y)));
  assign hit_ceiling = (y_sum <  $signed(11'(CEILING_Y)));

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg      <= IDLE;
      x_reg          <= 10'(X_START);
      y_reg          <= 10'(GROUND_Y);
      vy_reg         <= '0;
      facing_reg     <= 1'b0;
      jump_armed_reg <= 1'b1;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_avail_reg <= 1'b0;
`endif
    end else begin
      state_reg      <= state_next;
      x_reg          <= x_next;
      y_reg          <= y_next;
      vy_reg         <= vy_next;
      facing_reg     <= facing_next;
      jump_armed_reg <= jump_armed_next;
`ifdef PLAYER_DOUBLE_JUMP_EN
      air_jump_avail_reg <= air_jump_avail_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic (state transitions plus the motion datapath)
  // -------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    x_next          = x_reg;
    y_next          = y_reg;
    vy_next         = vy_reg;
    facing_next     = facing_reg;
    jump_armed_next = jump_armed_reg;
`ifdef PLAYER_DOUBLE_JUMP_EN
    air_jump_avail_next = air_jump_avail_reg;
`endif

    if (tick) begin
      // Horizontal motion applies in every state, including mid-air
      if (key_left) begin
        x_next      = (x_dec < 11'(X_MIN)) ? 10'(X_MIN) : x_dec[9:0];
        facing_next = 1'b1;
      end else if (key_right) begin
        x_next      = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
        facing_next = 1'b0;
      end

      // Releasing W re-arms; holding it never re-triggers
      if (!key_jump) jump_armed_next = 1'b1;

      unique case (state_reg)
        IDLE, WALK: begin
          if (key_jump && jump_armed_reg) begin
            // Takeoff tick keeps Y; the first rise happens next tick
            state_next      = JUMP;
            vy_next         = -$signed(6'(JUMP_V));
            jump_armed_next = 1'b0;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_jump_avail_next = 1'b1;
`endif
          end else begin
            state_next = key_move ? WALK : IDLE;
          end
        end

        JUMP: begin
`ifdef PLAYER_DOUBLE_JUMP_EN
          if (key_jump && jump_armed_reg && air_jump_avail_reg) begin
            vy_next             = -$signed(6'(JUMP_V));
            jump_armed_next     = 1'b0;
            air_jump_avail_next = 1'b0;
          end else
`endif
          if (hit_ground) begin
            // Landing tick already reports the grounded status
            y_next     = 10'(GROUND_Y);
            vy_next    = '0;
            state_next = key_move ? WALK : IDLE;
`ifdef PLAYER_DOUBLE_JUMP_EN
            air_jump_avail_next = 1'b0;
`endif
          end else if (hit_ceiling) begin
            y_next  = 10'(CEILING_Y);
            vy_next = '0;
          end else begin
            y_next  = y_sum[9:0];
            vy_next = vy_fall;
          end
        end

        default: state_next = IDLE;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Output logic (Moore: straight from registers)
  // -------------------------------------------------------------------------
  always_comb begin
    bus.BallX      = x_reg;
    bus.BallY      = y_reg;
    bus.Ball_sizeX = SPRITE_SIZE_X;
    bus.Ball_sizeY = SPRITE_SIZE_Y;
    bus.Facing     = facing_reg;
    bus.BallStatus = STATUS_IDLE;
    unique case (state_reg)
      IDLE:    bus.BallStatus = STATUS_IDLE;
      WALK:    bus.BallStatus = STATUS_WALK;
      JUMP:    bus.BallStatus = STATUS_JUMP;
      default: bus.BallStatus = STATUS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_player_motion.sv
// ---------------------------------------------------------------------------
// tb_player_motion
// Self-checking bench for player_motion. A frame driver issues keycodes and
// frame_clk edges; a reference model predicts the sprite after each frame
// and queues it; a monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_player_motion;

  logic Clk;
  logic Reset;

  player_motion_if bus ();

  player_motion dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

`ifdef PLAYER_DOUBLE_JUMP_EN
  localparam bit DJ = 1'b1;
`else
  localparam bit DJ = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int st;
    int face;
  } exp_t;

  exp_t exp_q[$];
  event chk_ev;

  // Reference model state (plain integers, status codes as sprite selects)
  int m_x, m_y, m_vy, m_st, m_face, m_armed, m_air;

  task automatic model_reset();
    m_x = 320; m_y = 400; m_vy = 0; m_st = 0; m_face = 0; m_armed = 1; m_air = 0;
  endtask

  task automatic model_frame(input logic [7:0] key);
    bit l, r, w;
    int ny;
    l = (key == 8'h04);
    r = (key == 8'h07);
    w = (key == 8'h1A);
    if (l) begin m_x = (m_x - 2 < 15) ? 15 : m_x - 2; m_face = 1; end
    if (r) begin m_x = (m_x + 2 > 624) ? 624 : m_x + 2; m_face = 0; end
    if (m_st != 2) begin
      if (w && m_armed == 1) begin
        m_st = 2; m_vy = -10; m_armed = 0; m_air = 1;
      end else begin
        m_st = (l || r) ? 1 : 0;
      end
    end else if (DJ && w && m_armed == 1 && m_air == 1) begin
      m_vy = -10; m_armed = 0; m_air = 0;
    end else begin
      ny = m_y + m_vy;
      if (ny >= 400) begin
        m_y = 400; m_vy = 0; m_air = 0; m_st = (l || r) ? 1 : 0;
      end else if (ny < 32) begin
        m_y = 32; m_vy = 0;
      end else begin
        m_y = ny; m_vy = (m_vy + 1 > 10) ? 10 : m_vy + 1;
      end
    end
    if (!w) m_armed = 1;
  endtask

  task automatic push_expected();
    exp_t e;
    e.x = m_x; e.y = m_y; e.st = m_st; e.face = m_face;
    exp_q.push_back(e);
    ->chk_ev;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: compares every queued prediction against the DUT outputs
  initial begin
    exp_t e;
    forever begin
      @(chk_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        if (bus.BallX !== 10'(e.x) || bus.BallY !== 10'(e.y) ||
            bus.BallStatus !== 4'(e.st) || bus.Facing !== 1'(e.face) ||
            bus.Ball_sizeX !== 10'd30 || bus.Ball_sizeY !== 10'd64) begin
          errors++;
          $display("FAIL frame: got X=%0d Y=%0d st=%0d face=%0d sz=%0dx%0d, expected X=%0d Y=%0d st=%0d face=%0d sz=30x64",
                   bus.BallX, bus.BallY, bus.BallStatus, bus.Facing,
                   bus.Ball_sizeX, bus.Ball_sizeY, e.x, e.y, e.st, e.face);
        end else begin
          $display("frame ok: X=%0d Y=%0d st=%0d face=%0d", e.x, e.y, e.st, e.face);
        end
      end
    end
  end

  // One frame: raise frame_clk with the key held, give the synchroniser and
  // update time, drop frame_clk, then hand the prediction to the monitor.
  task automatic do_frame(input logic [7:0] key);
    @(negedge Clk);
    bus.keycode   = key;
    bus.frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    bus.frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    model_frame(key);
    push_expected();
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    push_expected();
  endtask

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] key;
    int r;
    Reset = 1'b1;
    bus.frame_clk = 1'b0;
    bus.keycode = 8'h00;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    push_expected();
    chk("reset_x", int'(bus.BallX), 320);
    chk("reset_y", int'(bus.BallY), 400);
    chk("reset_status", int'(bus.BallStatus), 0);
    chk("reset_facing", int'(bus.Facing), 0);

    // Key held without any frame edge: nothing moves
    bus.keycode = 8'h07;
    repeat (20) @(negedge Clk);
    push_expected();
    chk("no_tick_x", int'(bus.BallX), 320);

    // Walk right 10 frames, then release
    for (int i = 0; i < 10; i++) do_frame(8'h07);
    chk("walk_x", int'(bus.BallX), 340);
    chk("walk_status", int'(bus.BallStatus), 1);
    chk("walk_facing", int'(bus.Facing), 0);
    do_frame(8'h00);
    chk("release_status", int'(bus.BallStatus), 0);

    // Right bound saturation, then left bound
    for (int i = 0; i < 200; i++) do_frame(8'h07);
    chk("right_bound", int'(bus.BallX), 624);
    for (int i = 0; i < 304; i++) do_frame(8'h04);
    chk("near_left_bound", int'(bus.BallX), 16);
    do_frame(8'h04);
    chk("left_bound", int'(bus.BallX), 15);
    do_frame(8'h04);
    chk("left_bound_hold", int'(bus.BallX), 15);
    chk("left_facing", int'(bus.Facing), 1);

    // Tap W: trajectory
    do_frame(8'h1A);
    chk("launch_status", int'(bus.BallStatus), 2);
    chk("launch_y", int'(bus.BallY), 400);
    for (int i = 1; i <= 21; i++) begin
      do_frame(8'h00);
      if (i == 1)  chk("jump_y1", int'(bus.BallY), 390);
      if (i == 2)  chk("jump_y2", int'(bus.BallY), 381);
      if (i == 10) chk("apex_y", int'(bus.BallY), 345);
      if (i == 11) chk("apex_hold_y", int'(bus.BallY), 345);
      if (i == 20) chk("air_status", int'(bus.BallStatus), 2);
      if (i == 21) begin
        chk("land_y", int'(bus.BallY), 400);
        chk("land_status", int'(bus.BallStatus), 0);
      end
    end

    // Hold W through landing: no re-trigger until released
    for (int i = 0; i < 25; i++) do_frame(8'h1A);
    chk("held_w_status", int'(bus.BallStatus), 0);
    do_frame(8'h00);
    do_frame(8'h1A);
    chk("rearm_status", int'(bus.BallStatus), 2);
    for (int i = 0; i < 22; i++) do_frame(8'h00);

    // Reset mid-jump
    do_frame(8'h1A);
    for (int i = 0; i < 5; i++) do_frame(8'h00);
    chk("midjump_y", int'(bus.BallY), 360);
    apply_reset();
    chk("rst_mid_y", int'(bus.BallY), 400);
    chk("rst_mid_status", int'(bus.BallStatus), 0);
    do_frame(8'h00);
    chk("rst_mid_settle_y", int'(bus.BallY), 400);

`ifdef PLAYER_DOUBLE_JUMP_EN
    do_frame(8'h1A);
    for (int i = 0; i < 10; i++) do_frame(8'h00);
    chk("dj_apex_y", int'(bus.BallY), 345);
    do_frame(8'h1A);
    do_frame(8'h00);
    chk("dj_rise_y", int'(bus.BallY), 335);
    do_frame(8'h00);
    do_frame(8'h1A);
    chk("dj_third_y", int'(bus.BallY), 318);
    for (int i = 0; i < 40; i++) do_frame(8'h00);
`endif

    // Randomised frames with occasional reset
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        apply_reset();
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2)      key = 8'h00;
        else if (r < 4) key = 8'h04;
        else if (r < 6) key = 8'h07;
        else if (r < 9) key = 8'h1A;
        else            key = 8'(8'h10 + $urandom_range(0, 8));
        do_frame(key);
      end
    end

    repeat (4) @(negedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
